// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, instruction register and RUN/HALTED FSM.
// Optional retired-fetch counter enabled by defining FETCH_PERF_COUNTER_EN.
module fetch_unit #(
  parameter int                     PC_WIDTH     = 32,
  parameter int                     INSTR_WIDTH  = 32,
  parameter int                     PC_STEP      = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD    = '1,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD     = 'h13
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  input  logic                   resume,
  output logic [PC_WIDTH-1:0]    imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    instruction_pc,
  output logic                   instruction_valid,
  output logic                   halted
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]            fetch_count
`endif
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(STEP - PC_WIDTH'(1));

  state_t              state;
  logic [PC_WIDTH-1:0] pc_p0;
  logic                is_halt;

  function automatic logic [PC_WIDTH-1:0] align_target(input logic [PC_WIDTH-1:0] target);
    return target & ALIGN_MASK;
  endfunction

  assign imem_address = pc_p0;
  assign is_halt      = instruction_valid && (instruction == HALT_WORD);

  // Stage p0 -> p1: pc advances while the fetched word lands in the instruction register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= RUN;
      halted            <= 1'b0;
      pc_p0             <= RESET_VECTOR;
      instruction       <= NOP_WORD;
      instruction_pc    <= RESET_VECTOR;
      instruction_valid <= 1'b0;
`ifdef FETCH_PERF_COUNTER_EN
      fetch_count       <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            pc_p0             <= align_target(redirect_target);
            instruction       <= NOP_WORD;
            instruction_valid <= 1'b0;
          end else if (is_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (!stall) begin
            instruction       <= imem_data;
            instruction_pc    <= pc_p0;
            instruction_valid <= 1'b1;
            pc_p0             <= pc_p0 + STEP;
`ifdef FETCH_PERF_COUNTER_EN
            if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
`endif
          end
        end
        HALTED: begin
          // pc already points past the halt word, so resuming continues in sequence
          if (resume) begin
            state             <= RUN;
            halted            <= 1'b0;
            instruction       <= NOP_WORD;
            instruction_valid <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; a second instance covers a wrapping reset vector.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        resume = 1'b0;
  logic        halt_en = 1'b0;

  logic [31:0] imem_address, imem_data, instruction, instruction_pc;
  logic        instruction_valid, halted;
  logic [31:0] w_address, w_data, w_instruction, w_pc;
  logic        w_valid, w_halted;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetch_count, w_fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign imem_data = (halt_en && imem_address == 32'd12) ? HALT : {imem_address[30:0], 1'b0};
  assign w_data    = {w_address[30:0], 1'b0};

  fetch_unit u_dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .resume(resume),
    .imem_address(imem_address), .imem_data(imem_data),
    .instruction(instruction), .instruction_pc(instruction_pc),
    .instruction_valid(instruction_valid), .halted(halted)
`ifdef FETCH_PERF_COUNTER_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut_wrap (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .resume(resume),
    .imem_address(w_address), .imem_data(w_data),
    .instruction(w_instruction), .instruction_pc(w_pc),
    .instruction_valid(w_valid), .halted(w_halted)
`ifdef FETCH_PERF_COUNTER_EN
    , .fetch_count(w_fetch_count)
`endif
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_address, instruction, instruction_pc, instruction_valid, halted} !== {32'd0, NOP, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got pc=%h ins=%h ipc=%h v=%b h=%b required pc=0 ins=%h ipc=0 v=0 h=0",
               imem_address, instruction, instruction_pc, instruction_valid, halted, NOP);
    end
`ifdef FETCH_PERF_COUNTER_EN
    checks++;
    if (fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count got %0d required 0", fetch_count);
    end
`endif
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1);
      exp_pc = 32'(i * 4);
      checks++;
      if ({instruction_pc, instruction, instruction_valid, imem_address} !== {exp_pc, exp_pc * 2, 1'b1, exp_pc + 32'd4}) begin
        errors++;
        $display("FAIL free_run[%0d] got ipc=%h ins=%h v=%b pc=%h required ipc=%h ins=%h v=1 pc=%h",
                 i, instruction_pc, instruction, instruction_valid, imem_address, exp_pc, exp_pc * 2, exp_pc + 32'd4);
      end
    end
`ifdef FETCH_PERF_COUNTER_EN
    checks++;
    if (fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL free_run_count got %0d required 4", fetch_count);
    end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    step(2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({imem_address, instruction, instruction_pc, instruction_valid} !== {32'd8, 32'd8, 32'd4, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got pc=%h ins=%h ipc=%h v=%b required pc=8 ins=8 ipc=4 v=1",
                 i, imem_address, instruction, instruction_pc, instruction_valid);
      end
    end
    stall = 1'b0;
    step(1);
    checks++;
    if ({instruction_pc, instruction, instruction_valid, imem_address} !== {32'd8, 32'd16, 1'b1, 32'd12}) begin
      errors++;
      $display("FAIL stall_release got ipc=%h ins=%h v=%b pc=%h required ipc=8 ins=10 v=1 pc=c",
               instruction_pc, instruction, instruction_valid, imem_address);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step(1);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h103;
    step(1);
    stall = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if ({imem_address, instruction, instruction_valid} !== {32'h100, NOP, 1'b0}) begin
      errors++;
      $display("FAIL redirect_bubble got pc=%h ins=%h v=%b required pc=100 ins=%h v=0",
               imem_address, instruction, instruction_valid, NOP);
    end
    step(1);
    checks++;
    if ({instruction_pc, instruction, instruction_valid, imem_address} !== {32'h100, 32'h200, 1'b1, 32'h104}) begin
      errors++;
      $display("FAIL redirect_target got ipc=%h ins=%h v=%b pc=%h required ipc=100 ins=200 v=1 pc=104",
               instruction_pc, instruction, instruction_valid, imem_address);
    end
  endtask

  task automatic test_halt();
    halt_en = 1'b1;
    do_reset();
    step(4);
    checks++;
    if ({instruction, instruction_pc, halted, imem_address} !== {HALT, 32'd12, 1'b0, 32'd16}) begin
      errors++;
      $display("FAIL halt_loaded got ins=%h ipc=%h h=%b pc=%h required ins=%h ipc=c h=0 pc=10",
               instruction, instruction_pc, halted, imem_address, HALT);
    end
    step(1);
    checks++;
    if ({halted, imem_address} !== {1'b1, 32'd16}) begin
      errors++;
      $display("FAIL halt_enter got h=%b pc=%h required h=1 pc=10", halted, imem_address);
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h400;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      step(1);
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if ({halted, imem_address, instruction, instruction_valid} !== {1'b1, 32'd16, HALT, 1'b1}) begin
      errors++;
      $display("FAIL halt_frozen got h=%b pc=%h ins=%h v=%b required h=1 pc=10 ins=%h v=1",
               halted, imem_address, instruction, instruction_valid, HALT);
    end
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    checks++;
    if ({halted, instruction_valid, instruction, imem_address} !== {1'b0, 1'b0, NOP, 32'd16}) begin
      errors++;
      $display("FAIL resume_bubble got h=%b v=%b ins=%h pc=%h required h=0 v=0 ins=%h pc=10",
               halted, instruction_valid, instruction, imem_address, NOP);
    end
    step(1);
    checks++;
    if ({instruction_pc, instruction, instruction_valid} !== {32'd16, 32'd32, 1'b1}) begin
      errors++;
      $display("FAIL resume_fetch got ipc=%h ins=%h v=%b required ipc=10 ins=20 v=1",
               instruction_pc, instruction, instruction_valid);
    end
`ifdef FETCH_PERF_COUNTER_EN
    checks++;
    if (fetch_count !== 32'd5) begin
      errors++;
      $display("FAIL halt_count got %0d required 5", fetch_count);
    end
`endif
    halt_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    do_reset();
    checks++;
    if ({w_address, w_pc, w_valid} !== {32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0}) begin
      errors++;
      $display("FAIL wrap_reset got pc=%h ipc=%h v=%b required pc=fffffff8 ipc=fffffff8 v=0",
               w_address, w_pc, w_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({w_pc, w_instruction, w_valid} !== {exp_pc[i], {exp_pc[i][30:0], 1'b0}, 1'b1}) begin
        errors++;
        $display("FAIL wrap_run[%0d] got ipc=%h ins=%h v=%b required ipc=%h ins=%h v=1",
                 i, w_pc, w_instruction, w_valid, exp_pc[i], {exp_pc[i][30:0], 1'b0});
      end
    end
    checks++;
    if (w_address !== 32'd4) begin
      errors++;
      $display("FAIL wrap_pc got %h required 4", w_address);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(3);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({imem_address, instruction, instruction_pc, instruction_valid, halted} !== {32'd0, NOP, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_run got pc=%h ins=%h ipc=%h v=%b h=%b required pc=0 ins=%h ipc=0 v=0 h=0",
               imem_address, instruction, instruction_pc, instruction_valid, halted, NOP);
    end
    @(negedge clock);
    reset = 1'b0;
    halt_en = 1'b1;
    step(5);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_prehalt got h=%b required 1", halted);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({imem_address, instruction, instruction_pc, instruction_valid, halted} !== {32'd0, NOP, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_halted got pc=%h ins=%h ipc=%h v=%b h=%b required pc=0 ins=%h ipc=0 v=0 h=0",
               imem_address, instruction, instruction_pc, instruction_valid, halted, NOP);
    end
`ifdef FETCH_PERF_COUNTER_EN
    checks++;
    if (fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_count got %0d required 0", fetch_count);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
    halt_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
